mem_store_unit: RTL and testbench

Multi-cycle store path of the CPU: the write-to-memory counterpart of the load/ALU write-back select. The control FSM pulses start in the MEM state of SB/SH/SW. The block captures address, rs2 data and funct3, replicates the data onto byte lanes and generates byte enables. It then runs a req/ack handshake with data memory and reports completion or an error back to control.

---
 rtl/mem_store_unit_if.sv | 28 ++
 rtl/mem_store_unit.sv | 120 ++++++++++++
 tb/tb_mem_store_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_unit_if.sv
// Store-unit bus: request/format inputs from control, memory write handshake
// and status back to control.
interface mem_store_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;

   // Environment side: control FSM plus data memory.
   modport master (
      output start, funct3, addr, store_data, mem_ack,
      input  mem_req, mem_addr, mem_wdata, mem_be, busy, done, err_code
   );

   // Store unit side.
   modport slave (
      input  start, funct3, addr, store_data, mem_ack,
      output mem_req, mem_addr, mem_wdata, mem_be, busy, done, err_code
   );
endinterface

// File: rtl/mem_store_unit.sv
// Multi-cycle store path: formats SB/SH/SW data onto byte lanes, runs the
// req/ack write handshake with a timeout, and reports done/err_code to control.
module mem_store_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input logic              clk,
   input logic              rst_n,
   mem_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_be;
   logic [1:0]          r_err;

   logic                w_illegal;
   logic                w_misal;
   logic                w_fault;
   logic                w_timeout;
   logic                w_accept;
   logic [31:0]         w_wdata;
   logic [3:0]          w_be;
   logic [1:0]          w_err_start;

   // Lane formatting and fault detection for the request presented with start.
   always_comb begin
      w_illegal = 1'b0;
      w_misal   = 1'b0;
      w_wdata   = '0;
      w_be      = '0;
      case (bus.funct3)
         3'b000: begin
            w_wdata = {4{bus.store_data[7:0]}};
            w_be    = 4'b0001 << bus.addr[1:0];
         end
         3'b001: begin
            w_wdata = {2{bus.store_data[15:0]}};
            w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
            w_misal = bus.addr[0];
         end
         3'b010: begin
            w_wdata = bus.store_data;
            w_be    = 4'b1111;
            w_misal = |bus.addr[1:0];
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal || w_misal) begin
         w_wdata = '0;
         w_be    = '0;
      end
   end

   assign w_fault     = w_illegal | w_misal;
   assign w_err_start = w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b00);
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_accept    = (r_state == IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state and state-decoded outputs; ack beats a coincident timeout.
   always_comb begin
      w_next       = r_state;
      bus.mem_req  = 1'b0;
      bus.busy     = 1'b1;
      bus.done     = 1'b0;
      case (r_state)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) w_next = w_fault ? FIN : REQ;
         end
         REQ: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack || w_timeout) w_next = FIN;
         end
         FIN: begin
            bus.done = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_err   <= 2'b00;
      end else begin
         if (r_state == REQ && w_next == REQ) r_cnt <= r_cnt + 1'b1;
         else                                 r_cnt <= '0;

         if (w_accept) begin
            r_addr  <= {bus.addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_err   <= w_err_start;
         end else if (r_state == REQ && !bus.mem_ack && w_timeout) begin
            r_err   <= 2'b10;
         end
      end
   end

   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_be    = r_be;
   assign bus.err_code  = r_err;

endmodule

// File: tb/tb_mem_store_unit.sv
// Randomized bench for mem_store_unit against a byte-lane reference model.
module tb_mem_store_unit;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mem_store_unit_if bus ();

   mem_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Store viewed as an access of 2**funct3 bytes starting at byte offset addr%4.
   function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic [1:0] err,
                                 output logic [3:0] be, output logic [31:0] wd);
      int size;
      int off;
      be  = '0;
      wd  = '0;
      err = 2'b00;
      if (f3 > 3'd2) begin
         err = 2'b11;
         return;
      end
      size = 1 << int'(f3);
      off  = int'(a[1:0]);
      if (off % size != 0) begin
         err = 2'b01;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         wd[8*i +: 8] = d[8*(i % size) +: 8];
         if (i >= off && i < off + size) be[i] = 1'b1;
      end
   endfunction

   // ack_at: index of the REQ cycle (0-based) on which ack is given; -1 = never.
   task automatic run_txn(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int ack_at, input bit poke);
      logic [1:0]  e_err;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      int          e_cycles;
      int          cycles;
      model(f3, a, d, e_err, e_be, e_wd);
      if (e_err == 2'b00) begin
         if (ack_at >= 0 && ack_at < TIMEOUT) e_cycles = ack_at + 1;
         else begin
            e_cycles = TIMEOUT;
            e_err    = 2'b10;
         end
      end else begin
         e_cycles = 0;
      end

      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.store_data = d;
      bus.mem_ack    = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start      = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.funct3     = 3'($urandom);
      bus.addr       = $urandom;
      bus.store_data = $urandom;

      cycles = 0;
      while (bus.mem_req && cycles <= TIMEOUT + 2) begin
         cycles++;
         if (cycles == 1 || cycles == e_cycles) begin
            check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
            check("mem_be", 32'(bus.mem_be), 32'(e_be));
            check("mem_wdata", bus.mem_wdata, e_wd);
            check("done_in_req", 32'(bus.done), 32'd0);
         end
         bus.mem_ack = (cycles - 1 == ack_at);
         bus.start   = poke && (cycles == 1);
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      bus.start   = 1'b0;

      check("req_cycles", 32'(cycles), 32'(e_cycles));
      check("done", 32'(bus.done), 32'd1);
      check("err_code", 32'(bus.err_code), 32'(e_err));
      check("busy_fin", 32'(bus.busy), 32'd1);
      check("req_fin", 32'(bus.mem_req), 32'd0);
      if (e_cycles == 0) begin
         check("err_be", 32'(bus.mem_be), 32'd0);
         check("err_wdata", bus.mem_wdata, 32'd0);
      end

      bus.start   = poke;
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start   = 1'b0;
      bus.mem_ack = 1'b0;
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
      check("err_hold", 32'(bus.err_code), 32'(e_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f3;
      int         ack_at;
      n_tests        = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.funct3     = 3'b000;
      bus.addr       = '0;
      bus.store_data = '0;
      bus.mem_ack    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req", 32'(bus.mem_req), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_addr", bus.mem_addr, 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      check("rst_be", 32'(bus.mem_be), 32'd0);
      check("rst_err", 32'(bus.err_code), 32'd0);
      rst_n = 1'b1;

      run_txn(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 2, 1'b0);
      run_txn(3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 1'b0);
      run_txn(3'b001, 32'h0000_3002, 32'h1234_CAFE, 1, 1'b0);
      run_txn(3'b001, 32'h0000_3001, 32'h1234_CAFE, 0, 1'b0);
      run_txn(3'b011, 32'h0000_4000, 32'h5555_AAAA, 0, 1'b0);
      run_txn(3'b111, 32'h0000_4001, 32'h5555_AAAA, 0, 1'b0);
      run_txn(3'b010, 32'h0000_4008, 32'h0BAD_F00D, -1, 1'b0);
      run_txn(3'b010, 32'h0000_400C, 32'h0BAD_F00D, TIMEOUT - 1, 1'b0);
      run_txn(3'b010, 32'h0000_4010, 32'hCAFE_0001, 3, 1'b1);

      // Reset asserted mid-REQ aborts without a done pulse.
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'b010;
      bus.addr       = 32'h0000_5008;
      bus.store_data = 32'h1111_2222;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("mid_req", 32'(bus.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", 32'(bus.mem_req), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_be", 32'(bus.mem_be), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_done", 32'(bus.done), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      run_txn(3'b010, 32'h0000_6000, 32'h7777_8888, 1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       ack_at = -1;
            1:       ack_at = TIMEOUT - 1;
            2:       ack_at = TIMEOUT;
            default: ack_at = int'($urandom_range(0, 5));
         endcase
         run_txn(f3, $urandom, $urandom, ack_at, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
